// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch responder.
//   fetch_state_e : request FSM states (issue a read / wait for its response)
//   fetch_entry_t : one buffered instruction {inst, pc, err}, 65 bits
//   RESET_PC      : value held in the request-PC register out of reset
package fetch_pkg;

  typedef enum logic [0:0] {
    StReq  = 1'b0,
    StWait = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
  } fetch_entry_t;

  localparam logic [31:0] RESET_PC = 32'h0;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO of fetched instructions toward decode.
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-low reset
//   flush             : empty the FIFO next cycle; wins over push and pop
//   push, push_data   : write one entry (never issued when full)
//   pop               : consume head entry (ignored when empty)
//   head_valid, head  : FIFO head entry to the consumer
//   count             : number of occupied entries (0..DEPTH)
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            push,
  input  fetch_entry_t    push_data,
  input  logic            pop,
  output logic            head_valid,
  output fetch_entry_t    head,
  output logic [CntW-1:0] count
);

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_pop;

  assign do_pop     = pop && (count_q != '0);
  assign head_valid = (count_q != '0);
  assign head       = mem_q[rd_ptr_q];
  assign count      = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(push) - CntW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_responder.sv
// Memory-side partner of the fetch unit. Issues one outstanding read per PC,
// buffers returned words toward decode and stalls the PC until each word lands.
// Ports:
//   clock, reset            : rising-edge clock, synchronous active-low reset
//   io_pc, io_flush         : PC from the fetch unit, redirect strobe
//   io_stall_en             : hold the fetch-unit PC
//   io_mem_req_*            : read request (valid/ready, address)
//   io_mem_rsp_*            : read response (valid, data, access fault)
//   io_inst_*               : FIFO head toward decode (valid/ready, word, pc, fault)
module instr_fetch_responder
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] io_pc,
  input  logic        io_flush,
  output logic        io_stall_en,
  output logic        io_mem_req_valid,
  output logic [31:0] io_mem_req_addr,
  input  logic        io_mem_req_ready,
  input  logic        io_mem_rsp_valid,
  input  logic [31:0] io_mem_rsp_data,
  input  logic        io_mem_rsp_err,
  output logic        io_inst_valid,
  output logic [31:0] io_inst,
  output logic [31:0] io_inst_pc,
  output logic        io_inst_err,
  input  logic        io_inst_ready
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic            drop_q, drop_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic            push;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;
  logic            head_valid;
  logic [CntW-1:0] count;
  logic            full;

  assign full            = (count == CntW'(DEPTH));
  assign io_mem_req_addr = io_pc;
  assign push_entry      = '{inst: io_mem_rsp_data, pc: req_pc_q, err: io_mem_rsp_err};

  always_comb begin
    state_d          = state_q;
    drop_d           = drop_q;
    req_pc_d         = req_pc_q;
    io_mem_req_valid = 1'b0;
    push             = 1'b0;

    unique case (state_q)
      StReq: begin
        io_mem_req_valid = reset && !full && !io_flush;
        if (io_mem_req_valid && io_mem_req_ready) begin
          req_pc_d = io_pc;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (io_mem_rsp_valid) begin
          state_d = StReq;
          // A response in the flush cycle belongs to the old path as well.
          if (drop_q || io_flush) begin
            drop_d = 1'b0;
          end else begin
            push = 1'b1;
          end
        end else if (io_flush) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = StReq;
    endcase

    // PC advances only when a word lands; a flush loads the redirect target.
    io_stall_en = !reset || !(push || io_flush);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= StReq;
      drop_q   <= 1'b0;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      drop_q   <= drop_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .flush      (io_flush),
    .push       (push),
    .push_data  (push_entry),
    .pop        (io_inst_ready),
    .head_valid (head_valid),
    .head       (head),
    .count      (count)
  );

  assign io_inst_valid = head_valid;
  assign io_inst       = head.inst;
  assign io_inst_pc    = head.pc;
  assign io_inst_err   = head.err;

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Bench for instr_fetch_responder: fetch-unit PC model, latency-programmable
// memory model and a scoreboard of words expected at decode.
module tb_instr_fetch_responder;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] io_pc;
  logic        io_flush = 1'b0;
  logic        io_stall_en;
  logic        io_mem_req_valid;
  logic [31:0] io_mem_req_addr;
  logic        io_mem_req_ready = 1'b0;
  logic        io_mem_rsp_valid = 1'b0;
  logic [31:0] io_mem_rsp_data = '0;
  logic        io_mem_rsp_err = 1'b0;
  logic        io_inst_valid;
  logic [31:0] io_inst;
  logic [31:0] io_inst_pc;
  logic        io_inst_err;
  logic        io_inst_ready = 1'b0;

  instr_fetch_responder #(
    .DEPTH(DEPTH)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .io_pc            (io_pc),
    .io_flush         (io_flush),
    .io_stall_en      (io_stall_en),
    .io_mem_req_valid (io_mem_req_valid),
    .io_mem_req_addr  (io_mem_req_addr),
    .io_mem_req_ready (io_mem_req_ready),
    .io_mem_rsp_valid (io_mem_rsp_valid),
    .io_mem_rsp_data  (io_mem_rsp_data),
    .io_mem_rsp_err   (io_mem_rsp_err),
    .io_inst_valid    (io_inst_valid),
    .io_inst          (io_inst),
    .io_inst_pc       (io_inst_pc),
    .io_inst_err      (io_inst_err),
    .io_inst_ready    (io_inst_ready)
  );

  always #5 clock = ~clock;

  // Environment knobs and model state.
  bit           mem_ready = 1'b1;
  bit           dec_ready = 1'b1;
  bit           flush_now = 1'b0;
  logic [31:0]  flush_target = '0;
  int           lat = 1;
  bit           ovr = 1'b0;
  logic [31:0]  ovr_data = '0;
  bit           pend = 1'b0;
  int           pend_cnt = 0;
  logic [31:0]  pend_addr = '0;
  bit           drop_model = 1'b0;
  logic [31:0]  exp_addr = '0;
  fetch_entry_t exp_q [$];
  int           nreq = 0;
  bit           hs_last = 1'b0;
  logic [31:0]  err_pc = '1;

  int total = 0;
  int bad = 0;

  // Fetch-unit PC register.
  always @(posedge clock) begin
    if (!reset) io_pc <= 32'h0;
    else if (io_flush) io_pc <= flush_target;
    else if (!io_stall_en) io_pc <= io_pc + 32'd4;
  end

  task automatic check_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'h13 ^ (a << 8);
  endfunction

  function automatic bit err_of(input logic [31:0] a);
    return a == 32'h8;
  endfunction

  // One clock cycle: drive at the falling edge, observe 1 ns later.
  task automatic tick();
    fetch_entry_t e;
    bit pushed;
    bit was_pend;
    @(negedge clock);
    io_flush         = flush_now;
    io_inst_ready    = dec_ready;
    io_mem_req_ready = mem_ready;
    io_mem_rsp_valid = 1'b0;
    io_mem_rsp_data  = '0;
    io_mem_rsp_err   = 1'b0;
    if (pend && pend_cnt == 0) begin
      io_mem_rsp_valid = 1'b1;
      io_mem_rsp_data  = ovr ? ovr_data : word_of(pend_addr);
      io_mem_rsp_err   = err_of(pend_addr);
    end
    #1;
    pushed   = 1'b0;
    was_pend = pend;
    hs_last  = 1'b0;

    if (io_inst_valid && io_inst_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("pop_empty", 65'(io_inst_valid), 65'(0));
      end else begin
        e = exp_q.pop_front();
        check_eq("inst", 65'(io_inst), 65'(e.inst));
        check_eq("inst_pc", 65'(io_inst_pc), 65'(e.pc));
        check_eq("inst_err", 65'(io_inst_err), 65'(e.err));
        if (io_inst_err) err_pc = io_inst_pc;
      end
    end

    if (io_mem_rsp_valid) begin
      pend = 1'b0;
      ovr  = 1'b0;
      if (drop_model || io_flush) begin
        drop_model = 1'b0;
      end else begin
        exp_q.push_back(fetch_entry_t'{inst: io_mem_rsp_data, pc: pend_addr,
                                       err: io_mem_rsp_err});
        pushed   = 1'b1;
        exp_addr = exp_addr + 32'd4;
      end
    end else if (pend) begin
      if (io_flush) drop_model = 1'b1;
      pend_cnt--;
    end

    if (io_flush) begin
      exp_q.delete();
      exp_addr = flush_target;
      check_eq("flush_noreq", 65'(io_mem_req_valid), 65'(0));
    end

    check_eq("stall", 65'(io_stall_en), 65'(!(pushed || io_flush)));

    if (io_mem_req_valid) begin
      nreq++;
      check_eq("one_outstanding", 65'(was_pend), 65'(0));
    end
    if (io_mem_req_valid && io_mem_req_ready) begin
      check_eq("req_addr", 65'(io_mem_req_addr), 65'(exp_addr));
      hs_last   = 1'b1;
      pend      = 1'b1;
      pend_cnt  = lat - 1;
      pend_addr = io_mem_req_addr;
    end
  endtask

  initial begin
    int  n0;
    bit  found;
    logic [31:0] addr0;

    // Reset values.
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    check_eq("rst_req_valid", 65'(io_mem_req_valid), 65'(0));
    check_eq("rst_stall", 65'(io_stall_en), 65'(1));
    check_eq("rst_inst_valid", 65'(io_inst_valid), 65'(0));
    check_eq("rst_inst", 65'(io_inst), 65'(0));
    check_eq("rst_inst_pc", 65'(io_inst_pc), 65'(0));
    check_eq("rst_inst_err", 65'(io_inst_err), 65'(0));
    @(posedge clock);
    #1 reset = 1'b1;

    // Minimum-latency first fetch, then streaming through the faulting PC 0x8.
    tick();
    check_eq("first_req", 65'(io_mem_req_valid), 65'(1));
    tick();
    check_eq("first_push_stall", 65'(io_stall_en), 65'(0));
    tick();
    check_eq("first_inst_valid", 65'(io_inst_valid), 65'(1));
    check_eq("first_inst", 65'(io_inst), 65'(32'h13));
    check_eq("first_inst_pc", 65'(io_inst_pc), 65'(0));
    check_eq("second_addr", 65'(io_mem_req_addr), 65'(32'h4));
    repeat (12) tick();
    check_eq("err_pc", 65'(err_pc), 65'(32'h8));

    // Decode back-pressure fills the FIFO and blocks further requests.
    dec_ready = 1'b0;
    repeat (10) tick();
    check_eq("held_valid", 65'(io_inst_valid), 65'(1));
    check_eq("buffered", 65'(exp_q.size()), 65'(DEPTH));
    n0 = nreq;
    repeat (4) tick();
    check_eq("no_req_full", 65'(nreq - n0), 65'(0));
    dec_ready = 1'b1;
    repeat (6) tick();

    // Flush while waiting on a slow response: the late word must be dropped.
    lat   = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (pend && pend_cnt > 0) found = 1'b1;
    end
    check_eq("wait_inflight", 65'(found), 65'(1));
    flush_now    = 1'b1;
    flush_target = 32'h100;
    ovr          = 1'b1;
    ovr_data     = 32'hDEADBEEF;
    tick();
    flush_now = 1'b0;
    tick();
    check_eq("flush_empty", 65'(io_inst_valid), 65'(0));
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (hs_last) found = 1'b1;
    end
    check_eq("wait_redirect", 65'(found), 65'(1));
    check_eq("redirect_addr", 65'(io_mem_req_addr), 65'(32'h100));
    lat = 1;
    repeat (6) tick();

    // Flush coinciding with a response and a pop.
    dec_ready = 1'b0;
    found     = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (pend && pend_cnt == 0 && io_inst_valid) found = 1'b1;
    end
    check_eq("wait_rsp_pop", 65'(found), 65'(1));
    flush_now    = 1'b1;
    flush_target = 32'h200;
    dec_ready    = 1'b1;
    tick();
    check_eq("flush_rsp_stall", 65'(io_stall_en), 65'(0));
    flush_now = 1'b0;
    tick();
    check_eq("flush_cnt0", 65'(io_inst_valid), 65'(0));
    check_eq("redirect2_valid", 65'(io_mem_req_valid), 65'(1));
    check_eq("redirect2_addr", 65'(io_mem_req_addr), 65'(32'h200));
    repeat (6) tick();

    // Memory not ready: request must hold steady.
    mem_ready = 1'b0;
    found     = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (io_mem_req_valid) found = 1'b1;
    end
    check_eq("wait_req", 65'(found), 65'(1));
    addr0 = io_mem_req_addr;
    repeat (5) begin
      tick();
      check_eq("hold_valid", 65'(io_mem_req_valid), 65'(1));
      check_eq("hold_addr", 65'(io_mem_req_addr), 65'(addr0));
    end
    mem_ready = 1'b1;
    repeat (8) tick();

    // Drain: everything the memory returned must have reached decode.
    mem_ready = 1'b0;
    repeat (10) tick();
    check_eq("drained", 65'(exp_q.size()), 65'(0));
    check_eq("final_empty", 65'(io_inst_valid), 65'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
